// File: rtl/parallel2serial.sv
// parallel2serial: buffers parallel words in a small circular FIFO and
// transmits each one as a contiguous burst of DATA_W serial bits with a
// per-bit valid and a last-bit marker.
//
// Handshake (valid/ready): the source presents din_parallel with din_valid;
// the word is taken at the rising edge where din_valid && din_ready.
// din_ready depends only on the FIFO count, never on din_valid. A source
// that sees din_ready low keeps din_valid and din_parallel stable.
//
// Optional feature macro: P2S_FRAME_GAP_EN. When defined, every frame is
// followed by one GAP cycle with dout_valid low before the FSM returns to
// IDLE. When undefined, frames run back to back with no bubble.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = SHIFT, 2 = GAP).
module parallel2serial #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           din_parallel,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        dout_serial,
    output logic                        dout_valid,
    output logic                        dout_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef P2S_FRAME_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;     // bits still to send after the current one
    logic [CNT_W-1:0]  r_bit_cnt;   // bits remaining after the current one
    logic              r_serial;
    logic              r_valid;
    logic              r_last;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_load_bit;
    logic [DATA_W-1:0] w_load_rem;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_next_rem;

    assign w_ready     = (r_count != LVL_W'(FIFO_DEPTH));
    assign w_push      = din_valid && w_ready;
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];

    // Bit selection for the first bit of a new word and for the next bit
    // of the word in flight; direction is fixed by LSB_FIRST.
    assign w_load_bit = (LSB_FIRST != 0) ? w_head[0]  : w_head[DATA_W-1];
    assign w_load_rem = (LSB_FIRST != 0) ? (w_head >> 1) : (w_head << 1);
    assign w_next_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_W-1];
    assign w_next_rem = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);

    // Pop decision: IDLE loads whenever a word is waiting; SHIFT chains the
    // next word on the last bit only when frames may run back to back.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_not_empty;
`ifndef P2S_FRAME_GAP_EN
            S_SHIFT: w_pop = (r_bit_cnt == '0) && w_not_empty;
`endif
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din_parallel;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serialiser FSM with registered serial, valid and last outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_serial  <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_serial  <= w_load_bit;
                        r_shift   <= w_load_rem;
                        r_bit_cnt <= CNT_W'(DATA_W - 1);
                        r_valid   <= 1'b1;
                        r_last    <= (DATA_W == 1);
                        r_state   <= S_SHIFT;
                    end else begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        r_serial  <= w_next_bit;
                        r_shift   <= w_next_rem;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        r_valid   <= 1'b1;
                        r_last    <= (r_bit_cnt == CNT_W'(1));
                    end else if (w_pop) begin
                        // Back-to-back frame: next word's first bit, no bubble.
                        r_serial  <= w_load_bit;
                        r_shift   <= w_load_rem;
                        r_bit_cnt <= CNT_W'(DATA_W - 1);
                        r_valid   <= 1'b1;
                        r_last    <= (DATA_W == 1);
                    end else begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
`ifdef P2S_FRAME_GAP_EN
                        r_state <= S_GAP;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef P2S_FRAME_GAP_EN
                S_GAP: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign din_ready   = w_ready;
    assign dout_serial = r_serial;
    assign dout_valid  = r_valid;
    assign dout_last   = r_last;
    assign fifo_level  = r_count;
    assign busy        = (r_state != S_IDLE) || w_not_empty;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_parallel2serial.sv
// tb_parallel2serial: directed plus random stimulus for two instances
// (MSB-first and LSB-first). A bit-level queue model predicts the serial
// stream, frame markers, FIFO level, ready and busy.
module tb_parallel2serial;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic [DW-1:0] m_data, l_data;
    logic          m_valid, l_valid;
    logic          m_ready, l_ready;
    logic          m_serial, l_serial;
    logic          m_dout_valid, l_dout_valid;
    logic          m_last, l_last;
    logic [2:0]    m_level, l_level;
    logic          m_busy, l_busy;
    logic [1:0]    m_dbg, l_dbg;

    always #5 clk = ~clk;

    parallel2serial #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(0)) dut (
        .clk(clk), .rst_n(rst_n), .din_parallel(m_data), .din_valid(m_valid),
        .din_ready(m_ready), .dout_serial(m_serial), .dout_valid(m_dout_valid),
        .dout_last(m_last), .fifo_level(m_level), .busy(m_busy), .dbg_state(m_dbg)
    );

    parallel2serial #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din_parallel(l_data), .din_valid(l_valid),
        .din_ready(l_ready), .dout_serial(l_serial), .dout_valid(l_dout_valid),
        .dout_last(l_last), .fifo_level(l_level), .busy(l_busy), .dbg_state(l_dbg)
    );

    // Scoreboard: expected serial bits, oldest first.
    logic exp_q[$];
    logic lexp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int pos = 0;
    int lpos = 0;
    int n_valid = 0;
    int n_last = 0;
    int n_rise = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_push_m(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic model_push_l(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) lexp_q.push_back(w[i]);
    endtask

    task automatic monitor();
        logic b;
        if (m_dout_valid) begin
            n_valid++;
            if (!prev_valid) n_rise++;
            if (m_last) n_last++;
            if (exp_q.size() == 0) begin
                check("m_spurious_bit", 32'(1), 32'(0));
            end else begin
                b = exp_q.pop_front();
                check("m_serial", 32'(m_serial), 32'(b));
                check("m_last", 32'(m_last), 32'(pos == DW - 1));
                pos = (pos + 1) % DW;
            end
        end else begin
            check("m_last_idle", 32'(m_last), 32'(0));
        end
        prev_valid = m_dout_valid;
        check("m_level", 32'(m_level), 32'(exp_q.size() / DW));
        check("m_ready", 32'(m_ready), 32'((exp_q.size() / DW) != DEPTH));
`ifdef P2S_FRAME_GAP_EN
        if (exp_q.size() != 0) check("m_busy", 32'(m_busy), 32'(1));
`else
        check("m_busy", 32'(m_busy), 32'((exp_q.size() != 0) || m_dout_valid));
`endif
        if (l_dout_valid) begin
            if (lexp_q.size() == 0) begin
                check("l_spurious_bit", 32'(1), 32'(0));
            end else begin
                b = lexp_q.pop_front();
                check("l_serial", 32'(l_serial), 32'(b));
                check("l_last", 32'(l_last), 32'(lpos == DW - 1));
                lpos = (lpos + 1) % DW;
            end
        end
        check("l_level", 32'(l_level), 32'(lexp_q.size() / DW));
    endtask

    // One clock: capture handshakes decided by the inputs set at this
    // negedge, advance to the next negedge, then compare outputs.
    task automatic tick();
        if (m_valid && m_ready) model_push_m(m_data);
        if (l_valid && l_ready) model_push_l(l_data);
        @(negedge clk);
        if (rst_n) monitor();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || lexp_q.size() != 0 || m_busy || l_busy) && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(k < budget), 32'(1));
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_last  = 0;
        n_rise  = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nxt;
        logic acc;
        logic saw_full;

        m_valid = 1'b0; m_data = '0;
        l_valid = 1'b0; l_data = '0;

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        check("rst_valid",  32'(m_dout_valid), 32'(0));
        check("rst_serial", 32'(m_serial), 32'(0));
        check("rst_last",   32'(m_last), 32'(0));
        check("rst_level",  32'(m_level), 32'(0));
        check("rst_busy",   32'(m_busy), 32'(0));
        check("rst_ready",  32'(m_ready), 32'(1));
        rst_n = 1'b1;
        tick();

        // Single word A5: two-cycle latency, eight bits, one last marker.
        clear_counts();
        m_valid = 1'b1; m_data = 8'hA5;
        tick();
        m_valid = 1'b0;
        check("lat_edge1_valid", 32'(m_dout_valid), 32'(0));
        tick();
        check("lat_edge2_valid", 32'(m_dout_valid), 32'(1));
        wait_idle(50);
        check("a5_bits", 32'(n_valid), 32'(8));
        check("a5_last", 32'(n_last), 32'(1));
        check("a5_busy_after", 32'(m_busy), 32'(0));

        // Two words on consecutive cycles.
        clear_counts();
        m_valid = 1'b1; m_data = 8'h3C;
        tick();
        m_data = 8'hC3;
        tick();
        m_valid = 1'b0;
        wait_idle(60);
        check("pair_bits", 32'(n_valid), 32'(16));
        check("pair_last", 32'(n_last), 32'(2));
`ifdef P2S_FRAME_GAP_EN
        check("pair_bursts", 32'(n_rise), 32'(2));
`else
        check("pair_bursts", 32'(n_rise), 32'(1));
`endif

        // Hold valid with incrementing data until six words are taken.
        clear_counts();
        nxt = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 200 && nxt < 6; c++) begin
            m_valid = 1'b1;
            m_data  = DW'(nxt);
            if (!m_ready && !saw_full) begin
                saw_full = 1'b1;
                check("full_level", 32'(m_level), 32'(DEPTH));
                check("full_shifting", 32'(m_dout_valid), 32'(1));
            end
            acc = m_ready;
            tick();
            if (acc) nxt++;
        end
        m_valid = 1'b0;
        check("stream_words", 32'(nxt), 32'(6));
        check("stream_saw_full", 32'(saw_full), 32'(1));
        wait_idle(200);
        check("stream_bits", 32'(n_valid), 32'(6 * DW));

        // Random traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            m_valid = 1'($urandom_range(0, 1));
            m_data  = DW'($urandom);
            l_valid = 1'($urandom_range(0, 1));
            l_data  = DW'($urandom);
            tick();
        end
        m_valid = 1'b0;
        l_valid = 1'b0;
        wait_idle(1000);

        // Reset mid-frame: FF shifting with two words queued behind it.
        m_valid = 1'b1; m_data = 8'hFF;
        tick();
        m_data = 8'h55;
        tick();
        m_data = 8'hAA;
        tick();
        m_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", 32'(m_dout_valid), 32'(1));
        check("pre_rst_level", 32'(m_level), 32'(2));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid",  32'(m_dout_valid), 32'(0));
        check("midrst_serial", 32'(m_serial), 32'(0));
        check("midrst_last",   32'(m_last), 32'(0));
        check("midrst_level",  32'(m_level), 32'(0));
        check("midrst_busy",   32'(m_busy), 32'(0));
        check("midrst_ready",  32'(m_ready), 32'(1));
        exp_q.delete();
        lexp_q.delete();
        pos = 0;
        lpos = 0;
        prev_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_counts();
        repeat (12) tick();
        check("post_rst_quiet", 32'(n_valid), 32'(0));
        m_valid = 1'b1; m_data = 8'h81;
        tick();
        m_valid = 1'b0;
        wait_idle(50);
        check("post_rst_bits", 32'(n_valid), 32'(8));

        // LSB-first instance: 01 sends a single leading one.
        l_valid = 1'b1; l_data = 8'h01;
        tick();
        l_valid = 1'b0;
        tick();
        check("lsb_first_valid", 32'(l_dout_valid), 32'(1));
        check("lsb_first_bit",   32'(l_serial), 32'(1));
        wait_idle(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
